// File: rtl/gpu_video_out.sv
// VGA pin stage: delay-matches counter timing to the late colour index, maps it through a
// double-buffered RGB444 palette and blanks outside the active area.
module gpu_video_out #(
    parameter int PIX_LAT  = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_xp,
    input  logic [7:0]  i_yp,
    input  logic        i_visible,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [3:0]  i_color_idx,
    input  logic        i_pal_we,
    input  logic [3:0]  i_pal_addr,
    input  logic [11:0] i_pal_wdata,
    input  logic        i_pal_commit,
    output logic        o_pal_pending,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic        o_hsync_out,
    output logic        o_vsync_out,
    output logic        o_frame_start
);

    localparam logic SYNC_INV = (SYNC_POL == 1'b0);

    // Timing bundle: [0] visible, [1] hsync, [2] vsync, [3] first pixel of frame
    logic       w_first;
    logic [3:0] w_tim_in;
    logic [3:0] w_tap;

    assign w_first  = i_visible && (i_xp == 8'd0) && (i_yp == 8'd0);
    assign w_tim_in = {w_first, i_vsync, i_hsync, i_visible};

    if (PIX_LAT == 0) begin : g_nodly
        assign w_tap = w_tim_in;
    end else begin : g_dly
        logic [3:0] r_stage [PIX_LAT];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int k = 0; k < PIX_LAT; k++) r_stage[k] <= '0;
            end else begin
                r_stage[0] <= w_tim_in;
                for (int k = 1; k < PIX_LAT; k++) r_stage[k] <= r_stage[k-1];
            end
        end

        assign w_tap = r_stage[PIX_LAT-1];
    end

    logic [11:0] r_stage_pal  [16];
    logic [11:0] r_active_pal [16];
    logic        r_vsync_q;
    logic        r_pending;
    logic        w_vs_rise;
    logic        w_commit;

    assign w_vs_rise = i_vsync && !r_vsync_q;
    assign w_commit  = w_vs_rise && (r_pending || i_pal_commit);

    // The copy reads staging before this edge's write, so a same-cycle write waits for the next commit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 16; k++) begin
                r_stage_pal[k]  <= '0;
                r_active_pal[k] <= '0;
            end
            r_vsync_q <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_vsync_q <= i_vsync;
            if (i_pal_we) r_stage_pal[i_pal_addr] <= i_pal_wdata;
            if (w_commit) begin
                for (int k = 0; k < 16; k++) r_active_pal[k] <= r_stage_pal[k];
            end
            r_pending <= w_commit ? 1'b0 : (r_pending || i_pal_commit);
        end
    end

    logic [11:0] r_rgb;
    logic        r_hs_out;
    logic        r_vs_out;
    logic        r_fs;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rgb    <= '0;
            r_hs_out <= SYNC_INV;
            r_vs_out <= SYNC_INV;
            r_fs     <= 1'b0;
        end else begin
            r_rgb    <= w_tap[0] ? r_active_pal[i_color_idx] : 12'h000;
            r_hs_out <= w_tap[1] ^ SYNC_INV;
            r_vs_out <= w_tap[2] ^ SYNC_INV;
            r_fs     <= w_tap[3];
        end
    end

    assign o_red         = r_rgb[11:8];
    assign o_green       = r_rgb[7:4];
    assign o_blue        = r_rgb[3:0];
    assign o_hsync_out   = r_hs_out;
    assign o_vsync_out   = r_vs_out;
    assign o_frame_start = r_fs;
    assign o_pal_pending = r_pending;

endmodule

// File: tb/tb_gpu_video_out.sv
// Bench for gpu_video_out: instance a uses PIX_LAT=2/SYNC_POL=0, instance b PIX_LAT=0/SYNC_POL=1,
// both driven by the same stimulus.
module tb_gpu_video_out;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, visible, hsync, vsync, pal_we, pal_commit;
    logic [7:0]  xp, yp;
    logic [3:0]  cidx, pal_addr;
    logic [11:0] pal_wdata;

    logic        a_pend, a_hs, a_vs, a_fs, b_pend, b_hs, b_vs, b_fs;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic [11:0] rgb_a, rgb_b;
    assign rgb_a = {a_r, a_g, a_b};
    assign rgb_b = {b_r, b_g, b_b};

    gpu_video_out #(.PIX_LAT(2), .SYNC_POL(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_xp(xp), .i_yp(yp), .i_visible(visible),
        .i_hsync(hsync), .i_vsync(vsync), .i_color_idx(cidx), .i_pal_we(pal_we),
        .i_pal_addr(pal_addr), .i_pal_wdata(pal_wdata), .i_pal_commit(pal_commit),
        .o_pal_pending(a_pend), .o_red(a_r), .o_green(a_g), .o_blue(a_b),
        .o_hsync_out(a_hs), .o_vsync_out(a_vs), .o_frame_start(a_fs));

    gpu_video_out #(.PIX_LAT(0), .SYNC_POL(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_xp(xp), .i_yp(yp), .i_visible(visible),
        .i_hsync(hsync), .i_vsync(vsync), .i_color_idx(cidx), .i_pal_we(pal_we),
        .i_pal_addr(pal_addr), .i_pal_wdata(pal_wdata), .i_pal_commit(pal_commit),
        .o_pal_pending(b_pend), .o_red(b_r), .o_green(b_g), .o_blue(b_b),
        .o_hsync_out(b_hs), .o_vsync_out(b_vs), .o_frame_start(b_fs));

    int n_checks = 0;
    int n_err    = 0;

    logic [11:0] stage_m [16];
    logic [11:0] act_m   [16];

    typedef struct packed {
        logic        vis;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        hs;
        logic        vs;
        logic [3:0]  idx;
        logic [11:0] rgb;
        logic        hs_a;
        logic        vs_a;
        logic        fs;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        visible = 0; hsync = 0; vsync = 0; xp = 0; yp = 0; cidx = 0;
        pal_we = 0; pal_addr = 0; pal_wdata = 0; pal_commit = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        pal_we = 1; pal_addr = a; pal_wdata = d;
        tick();
        pal_we = 0;
        stage_m[a] = d;
    endtask

    // Commit request coincident with a vsync rise: copy happens immediately, nothing left pending.
    task automatic commit_now(input string nm);
        pal_commit = 1; vsync = 1;
        tick();
        pal_commit = 0; vsync = 0;
        for (int k = 0; k < 16; k++) act_m[k] = stage_m[k];
        chk({nm, "_pend_a"}, {11'd0, a_pend}, 12'd0);
        tick();
    endtask

    task automatic vpulse();
        vsync = 1; tick();
        vsync = 0; tick();
    endtask

    task automatic show(input logic [3:0] idx);
        visible = 1; xp = 8'd3; yp = 8'd1; cidx = idx;
        repeat (4) tick();
    endtask

    initial begin
        int first_a, first_b, cnt_a, cnt_b;
        logic dirty;

        idle_inputs();
        rst = 1;
        for (int k = 0; k < 16; k++) begin stage_m[k] = 0; act_m[k] = 0; end
        tick(); tick();
        rst = 0;
        tick();

        // Mid-frame reset with a pending commit and non-zero palette
        wr(4'd1, 12'hABC);
        commit_now("pre_rst");
        pal_commit = 1; tick(); pal_commit = 0;
        chk("pre_rst_pending", {11'd0, a_pend}, 12'd1);
        visible = 1; cidx = 1; hsync = 1; xp = 8'd5;
        tick(); tick();
        rst = 1;
        tick();
        chk("rst_rgb_a", rgb_a, 12'h000);
        chk("rst_rgb_b", rgb_b, 12'h000);
        chk("rst_hs_a",  {11'd0, a_hs}, 12'd1);
        chk("rst_vs_a",  {11'd0, a_vs}, 12'd1);
        chk("rst_hs_b",  {11'd0, b_hs}, 12'd0);
        chk("rst_vs_b",  {11'd0, b_vs}, 12'd0);
        chk("rst_fs_a",  {11'd0, a_fs}, 12'd0);
        chk("rst_pend_a", {11'd0, a_pend}, 12'd0);
        chk("rst_pend_b", {11'd0, b_pend}, 12'd0);
        rst = 0; hsync = 0;
        for (int k = 0; k < 16; k++) begin stage_m[k] = 0; act_m[k] = 0; end
        repeat (4) tick();
        chk("rst_pal_a", rgb_a, 12'h000);
        chk("rst_pal_b", rgb_b, 12'h000);
        idle_inputs();
        tick();

        // Palette entry i = {i, i, 15-i}
        for (int i = 0; i < 16; i++) wr(4'(i), {4'(i), 4'(i), 4'(15 - i)});
        commit_now("init");

        vecs[0] = '{1'b1, 8'd10,  8'd3,   1'b0, 1'b0, 4'd3,  12'h33C, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'd0,   8'd0,   1'b0, 1'b0, 4'd10, 12'hAA5, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 8'd20,  8'd5,   1'b1, 1'b0, 4'd15, 12'h000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'd20,  8'd5,   1'b0, 1'b1, 4'd3,  12'h000, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'd0,   8'd7,   1'b0, 1'b0, 4'd15, 12'hFF0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'd9,   8'd0,   1'b0, 1'b0, 4'd0,  12'h00F, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'd0,   8'd0,   1'b1, 1'b1, 4'd10, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'd255, 8'd255, 1'b0, 1'b0, 4'd10, 12'hAA5, 1'b1, 1'b1, 1'b0};

        foreach (vecs[i]) begin
            visible = vecs[i].vis; xp = vecs[i].x; yp = vecs[i].y;
            hsync = vecs[i].hs; vsync = vecs[i].vs; cidx = vecs[i].idx;
            repeat (4) tick();
            chk($sformatf("vec%0d_rgb_a", i), rgb_a, vecs[i].rgb);
            chk($sformatf("vec%0d_rgb_b", i), rgb_b, vecs[i].rgb);
            chk($sformatf("vec%0d_hs_a", i), {11'd0, a_hs}, {11'd0, vecs[i].hs_a});
            chk($sformatf("vec%0d_vs_a", i), {11'd0, a_vs}, {11'd0, vecs[i].vs_a});
            chk($sformatf("vec%0d_hs_b", i), {11'd0, b_hs}, {11'd0, ~vecs[i].hs_a});
            chk($sformatf("vec%0d_vs_b", i), {11'd0, b_vs}, {11'd0, ~vecs[i].vs_a});
            chk($sformatf("vec%0d_fs_a", i), {11'd0, a_fs}, {11'd0, vecs[i].fs});
            chk($sformatf("vec%0d_fs_b", i), {11'd0, b_fs}, {11'd0, vecs[i].fs});
        end
        idle_inputs();
        repeat (4) tick();

        // Latency: pixel (0,0) with idx 3 = F80 must hit pins 3 cycles (a) / 1 cycle (b) later
        wr(4'd3, 12'hF80);
        commit_now("lat");
        cidx = 3;
        repeat (4) tick();
        visible = 1; xp = 0; yp = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            xp = 8'(t);
            chk($sformatf("lat_t%0d_rgb_a", t), rgb_a, (t >= 3) ? 12'hF80 : 12'h000);
            chk($sformatf("lat_t%0d_fs_a", t), {11'd0, a_fs}, (t == 3) ? 12'd1 : 12'd0);
            chk($sformatf("lat_t%0d_rgb_b", t), rgb_b, 12'hF80);
            chk($sformatf("lat_t%0d_fs_b", t), {11'd0, b_fs}, (t == 1) ? 12'd1 : 12'd0);
        end
        idle_inputs();
        repeat (4) tick();

        // Blanked colour and 48-cycle hsync pulse
        wr(4'd3, 12'hFFF);
        commit_now("hs");
        cidx = 3;
        repeat (4) tick();
        first_a = 0; first_b = 0; cnt_a = 0; cnt_b = 0; dirty = 0;
        for (int t = 1; t <= 60; t++) begin
            hsync = (t <= 48);
            tick();
            if (a_hs == 1'b0) begin cnt_a++; if (first_a == 0) first_a = t; end
            if (b_hs == 1'b1) begin cnt_b++; if (first_b == 0) first_b = t; end
            if (rgb_a != 12'h000 || rgb_b != 12'h000) dirty = 1;
        end
        chk("hs_blank_rgb", {11'd0, dirty}, 12'd0);
        chk("hs_len_a",   12'(cnt_a), 12'd48);
        chk("hs_first_a", 12'(first_a), 12'd3);
        chk("hs_len_b",   12'(cnt_b), 12'd48);
        chk("hs_first_b", 12'(first_b), 12'd1);
        idle_inputs();
        tick();

        // Staging write without commit is invisible across vsyncs; commit waits for next vsync rise
        wr(4'd5, 12'h0F0);
        vpulse(); vpulse();
        show(4'd5);
        chk("stage_hold_a", rgb_a, 12'h55A);
        chk("stage_hold_b", rgb_b, 12'h55A);
        idle_inputs();
        pal_commit = 1; tick(); pal_commit = 0;
        chk("pend_set", {11'd0, a_pend}, 12'd1);
        repeat (3) tick();
        chk("pend_hold", {11'd0, b_pend}, 12'd1);
        pal_commit = 1; tick(); pal_commit = 0;
        chk("pend_recommit", {11'd0, a_pend}, 12'd1);
        vsync = 1; tick(); vsync = 0;
        for (int k = 0; k < 16; k++) act_m[k] = stage_m[k];
        chk("pend_clear", {11'd0, a_pend}, 12'd0);
        tick();
        show(4'd5);
        chk("commit5_a", rgb_a, 12'h0F0);
        chk("commit5_b", rgb_b, 12'h0F0);
        idle_inputs();
        tick();

        // Write landing on the commit edge goes to staging only
        wr(4'd2, 12'h123);
        pal_commit = 1; tick(); pal_commit = 0;
        vsync = 1; pal_we = 1; pal_addr = 4'd2; pal_wdata = 12'h00F;
        tick();
        vsync = 0; pal_we = 0;
        for (int k = 0; k < 16; k++) act_m[k] = stage_m[k];
        stage_m[2] = 12'h00F;
        chk("sim_pend", {11'd0, b_pend}, 12'd0);
        tick();
        show(4'd2);
        chk("sim_old_a", rgb_a, 12'h123);
        chk("sim_old_b", rgb_b, 12'h123);
        idle_inputs();
        tick();
        commit_now("sim2");
        show(4'd2);
        chk("sim_new_a", rgb_a, 12'h00F);
        chk("sim_new_b", rgb_b, 12'h00F);

        // Sweep every index across consecutive visible pixels
        visible = 1; xp = 0; yp = 8'd4; cidx = 0;
        tick(); tick();
        for (int k = 0; k < 16; k++) begin
            cidx = 4'(k); xp = 8'(k);
            tick();
            chk($sformatf("sweep%0d_b", k), rgb_b, act_m[k]);
            chk($sformatf("sweep%0d_a", k), rgb_a, act_m[k]);
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
